// File: rtl/mux_sel_arbiter_if.sv
// Control bundle between the four source units, the arbiter and the downstream consumer.
// Latency: none (wires only); grant/sel are registered inside the arbiter, out_valid is combinational.
// Backpressure: out_ready from the consumer stalls the current owner's beat; no data travels here.
//
// Signals:
//   req[3:0]   per-requester request, held for the whole tenure
//   last[3:0]  per-requester final-beat flag, only the owner's bit matters
//   out_ready  consumer ready
//   grant[3:0] one-hot registered grant, zero while idle
//   sel[1:0]   registered mux select (owner index), holds last owner while idle
//   out_valid  owner is requesting while the arbiter is busy
//   busy       arbiter has an owner
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;

  // Arbiter side.
  modport master (
    input  req,
    input  last,
    input  out_ready,
    output grant,
    output sel,
    output out_valid,
    output busy
  );

  // Source/consumer side.
  modport slave (
    output req,
    output last,
    output out_ready,
    input  grant,
    input  sel,
    input  out_valid,
    input  busy
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, with a per-tenure burst cap.
// Latency: one cycle from request to grant; back-to-back tenures re-arbitrate with no idle bubble.
// Backpressure: out_ready low stalls the owner; beat count, grant and sel hold until it returns.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   bus          mux_sel_arbiter_if.master (req, last, out_ready in; grant, sel, out_valid, busy out)
module mux_sel_arbiter #(
  parameter int MAX_BURST = 4,   // beats per tenure, 1..7
  parameter int CNT_W     = 3    // 2**CNT_W > MAX_BURST
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.master  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic       is_busy;
  logic       owner_req;
  logic       out_valid;
  logic       xfer;
  logic       burst_done;
  logic       tenure_end;
  logic [1:0] scan_start;
  logic [1:0] scan_idx;
  logic       win_found;
  logic [1:0] win_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 4'b0000;
      sel_q      <= 2'd0;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    is_busy    = (state_q == ST_BUSY);
    owner_req  = bus.req[sel_q];
    out_valid  = is_busy && owner_req;
    xfer       = out_valid && bus.out_ready;
    // Counter holds beats already moved, so this beat is the cap when it reads MAX_BURST-1.
    burst_done = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    // An owner dropping req aborts the tenure; otherwise it ends on a beat that is last or hits the cap.
    tenure_end = is_busy && (!owner_req || (xfer && (bus.last[sel_q] || burst_done)));

    // From idle the scan starts at the stored pointer; when a tenure ends it starts just past
    // the owner, so the owner is considered last and only wins again if nobody else asks.
    scan_start = is_busy ? (sel_q + 2'd1) : rr_ptr_q;
    win_found  = 1'b0;
    win_idx    = 2'd0;
    scan_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = scan_start + 2'(i);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_BUSY;
          grant_d    = 4'b0001 << win_idx;
          sel_d      = win_idx;
          beat_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (tenure_end) begin
          rr_ptr_d = sel_q + 2'd1;
          if (win_found) begin
            // Hand over directly; the new owner starts its tenure on the next edge.
            grant_d    = 4'b0001 << win_idx;
            sel_d      = win_idx;
            beat_cnt_d = '0;
          end else begin
            // sel keeps the previous owner while idle.
            state_d = ST_IDLE;
            grant_d = 4'b0000;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = is_busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: transaction-level model plus directed scenarios.
// Latency: model grants one edge after a request, mirroring the arbiter's registered outputs.
// Backpressure: the bench drives out_ready patterns to exercise stalls.
module tb_mux_sel_arbiter;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;

  mux_sel_arbiter_if bus_if ();

  mux_sel_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model: who owns the mux, for how many beats ----------------
  bit m_busy;
  int m_owner;      // current owner, or previous owner while idle
  int m_beats;      // beats moved in the current tenure
  int m_ptr;        // where the next idle scan begins
  int log_owner[$]; // completed tenures: owner ...
  int log_beats[$]; // ... and the beats it moved

  function automatic int pick(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_beats = 0;
      m_ptr   = 0;
    end else if (!m_busy) begin
      if (pick(m_ptr, bus_if.req) >= 0) begin
        m_owner = pick(m_ptr, bus_if.req);
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else begin
      bit done;
      done = 1'b0;
      if (!bus_if.req[m_owner]) begin
        done = 1'b1;
      end else if (bus_if.out_ready) begin
        m_beats++;
        if (bus_if.last[m_owner] || m_beats == MAX_BURST) done = 1'b1;
      end
      if (done) begin
        log_owner.push_back(m_owner);
        log_beats.push_back(m_beats);
        m_ptr = (m_owner + 1) % 4;
        if (bus_if.req != 4'b0000) begin
          m_owner = pick(m_ptr, bus_if.req);
          m_beats = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- compare every cycle, away from the active edge ----------------
  always @(negedge clk) begin
    logic [3:0] e_grant;
    e_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("grant", {28'd0, bus_if.grant}, {28'd0, e_grant});
    chk("sel", {30'd0, bus_if.sel}, 32'(m_owner));
    chk("busy", {31'd0, bus_if.busy}, {31'd0, m_busy});
    chk("out_valid", {31'd0, bus_if.out_valid}, {31'd0, (m_busy && bus_if.req[m_owner])});
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    log_owner.delete();
    log_beats.delete();
  endtask

  initial begin
    bit rdy_pat[6];
    rst_n            = 1'b0;
    bus_if.req       = 4'b0000;
    bus_if.last      = 4'b0000;
    bus_if.out_ready = 1'b0;
    #12;
    rst_n = 1'b1;

    // Reset state
    chk("rst_grant", {28'd0, bus_if.grant}, 32'h0);
    chk("rst_sel", {30'd0, bus_if.sel}, 32'h0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'h0);

    // Single requester 2, last on beat 2
    bus_if.req       = 4'b0100;
    bus_if.out_ready = 1'b1;
    step(1);
    chk("t1_grant", {28'd0, bus_if.grant}, 32'h4);
    chk("t1_sel", {30'd0, bus_if.sel}, 32'd2);
    step(1);
    bus_if.last = 4'b0100;
    step(1);
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    step(1);
    chk("t1_idle_grant", {28'd0, bus_if.grant}, 32'h0);
    chk("t1_idle_busy", {31'd0, bus_if.busy}, 32'h0);
    chk("t1_beats", 32'(log_beats[0]), 32'd2);
    chk("t1_ptr", 32'(m_ptr), 32'd3);

    // All four requesting: 0,1,2,3,0 with capped tenures
    do_reset();
    bus_if.req = 4'b1111;
    step(21);
    chk("t2_count", 32'(log_owner.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_owner%0d", i), 32'(log_owner[i]), 32'(i % 4));
      chk($sformatf("t2_beats%0d", i), 32'(log_beats[i]), 32'd4);
    end
    bus_if.req = 4'b0000;
    step(2);

    // Owner 1 with stalls
    do_reset();
    bus_if.req = 4'b0010;
    step(1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus_if.out_ready = rdy_pat[i];
      #1;
      if (!rdy_pat[i]) begin
        chk("t3_stall_grant", {28'd0, bus_if.grant}, 32'h2);
        chk("t3_stall_sel", {30'd0, bus_if.sel}, 32'd1);
      end
      step(1);
    end
    chk("t3_owner", 32'(log_owner[0]), 32'd1);
    chk("t3_beats", 32'(log_beats[0]), 32'd4);
    bus_if.out_ready = 1'b1;
    bus_if.req       = 4'b0000;
    step(2);

    // Owner 2 aborts after one beat while requester 0 waits
    do_reset();
    bus_if.req = 4'b0100;
    step(1);
    bus_if.req = 4'b0101;
    step(1);
    bus_if.req = 4'b0001;
    #1;
    chk("t4_valid_drop", {31'd0, bus_if.out_valid}, 32'h0);
    step(1);
    chk("t4_grant0", {28'd0, bus_if.grant}, 32'h1);
    chk("t4_abort_beats", 32'(log_beats[0]), 32'd1);
    bus_if.last = 4'b0001;
    step(1);
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    step(2);

    // Lone requester 0 re-granted each tenure
    do_reset();
    bus_if.req = 4'b0001;
    step(17);
    chk("t5_count", 32'(log_owner.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_owner%0d", i), 32'(log_owner[i]), 32'd0);
      chk($sformatf("t5_beats%0d", i), 32'(log_beats[i]), 32'd4);
    end
    bus_if.req = 4'b0000;
    step(2);

    // Asynchronous reset mid-burst
    bus_if.req = 4'b0011;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", {28'd0, bus_if.grant}, 32'h0);
    chk("t6_sel", {30'd0, bus_if.sel}, 32'h0);
    chk("t6_busy", {31'd0, bus_if.busy}, 32'h0);
    chk("t6_valid", {31'd0, bus_if.out_valid}, 32'h0);
    #3;
    rst_n      = 1'b1;
    bus_if.req = 4'b0010;
    step(1);
    chk("t6_sel_after", {30'd0, bus_if.sel}, 32'd1);
    chk("t6_grant_after", {28'd0, bus_if.grant}, 32'h2);
    bus_if.req = 4'b0000;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
